// File: rtl/pdh_pkg.sv
// Shared types and lane geometry for the DAC AXI-Stream transmitter.
package pdh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int LANE_W    = 16;
  localparam int LANE1_OFF = 0;
  localparam int LANE2_OFF = 16;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a combinational head; 1-cycle push-to-visible latency.
// A push while full is accepted only when a pop happens in the same cycle; otherwise it is dropped.
module axis_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gating the head keeps tdata at zero whenever nothing is queued, including reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_axis_tx.sv
// Packs two DAC channels into AXI-Stream beats via a small FIFO; write at N gives tvalid at N+1.
// Backpressure queues beats, overflow is sticky; optional ramp generator under DAC_TX_RAMP_EN.
module dac_axis_tx
  import pdh_pkg::*;
#(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic                        wr_en_i,
  input  logic [1:0]                  ch_sel_i,
  input  logic [DAC_DATA_WIDTH-1:0]   data_i,
  input  logic                        clr_i,
  input  logic                        ramp_i,
  input  logic [DAC_DATA_WIDTH-1:0]   step_i,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata_o,
  output logic                        M_AXIS_tvalid_o,
  input  logic                        M_AXIS_tready_i,
  output logic [7:0]                  callback_o
);

  localparam int DW    = DAC_DATA_WIDTH;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                  rst_sync;
  logic                        arst_n;
  state_t                      state, state_nxt;
  logic [DW-1:0]               ch1_q, ch2_q, ch1_nxt, ch2_nxt, lane1, lane2;
  logic                        wr_acc, hold_upd, push, pop, full, empty, ovf_q;
  logic [AXIS_TDATA_WIDTH-1:0] beat;
  logic [LVL_W-1:0]            level;

  function automatic logic [LANE_W-1:0] sext(input logic [DW-1:0] s);
    return {{(LANE_W-DW){s[DW-1]}}, s};
  endfunction

  // Assertion is immediate, release is retimed through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign arst_n = rst_sync[1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (en_i) state_nxt = ST_RUN;
      ST_RUN:   if (!en_i) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (en_i)       state_nxt = ST_RUN;
        else if (empty) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign wr_acc = (state == ST_RUN) && en_i && wr_en_i;

  always_comb begin
    ch1_nxt = ch_sel_i[0] ? data_i : ch1_q;
    ch2_nxt = ch_sel_i[1] ? data_i : ch2_q;
  end

`ifdef DAC_TX_RAMP_EN
  logic [DW-1:0] acc_q;
  logic          ramp_act;

  assign ramp_act = (state == ST_RUN) && en_i && ramp_i;

  // Accumulator wraps naturally in DW bits (+max -> -min).
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                acc_q <= '0;
    else if (ramp_act && !full) acc_q <= acc_q + step_i;
  end

  always_comb begin
    if (ramp_act) begin
      push     = !full;
      lane1    = acc_q;
      lane2    = ch2_q;
      hold_upd = 1'b0;
    end else begin
      push     = wr_acc;
      lane1    = ch1_nxt;
      lane2    = ch2_nxt;
      hold_upd = wr_acc;
    end
  end
`else
  logic unused_ramp;
  assign unused_ramp = ^{ramp_i, step_i};
  assign push        = wr_acc;
  assign lane1       = ch1_nxt;
  assign lane2       = ch2_nxt;
  assign hold_upd    = wr_acc;
`endif

  always_comb begin
    beat = '0;
    beat[LANE1_OFF +: LANE_W] = sext(lane1);
    beat[LANE2_OFF +: LANE_W] = sext(lane2);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ch1_q <= '0;
      ch2_q <= '0;
    end else if (hold_upd) begin
      ch1_q <= ch1_nxt;
      ch2_q <= ch2_nxt;
    end
  end

  assign M_AXIS_tvalid_o = !empty;
  assign pop             = M_AXIS_tvalid_o && M_AXIS_tready_i;

  // A fresh overflow beats a coincident clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                  ovf_q <= 1'b0;
    else if (push && full && !pop) ovf_q <= 1'b1;
    else if (clr_i)               ovf_q <= 1'b0;
  end

  axis_sync_fifo #(
    .W     (AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (arst_n),
    .push  (push),
    .din   (beat),
    .pop   (pop),
    .dout  (M_AXIS_tdata_o),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign callback_o = {state, ovf_q, 5'(level)};

endmodule

// File: doc/dac_axis_tx.md
DAC_AXIS_TX -- requirements
Module: dac_axis_tx

Interface
REQ-001 SHALL take parameter DAC_DATA_WIDTH, default 14: DAC sample width, two's complement.
REQ-002 SHALL take parameter AXIS_TDATA_WIDTH, default 32: two 16-bit lanes per beat.
REQ-003 SHALL take parameter FIFO_DEPTH, default 4: output FIFO entries, power of two.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  system clock, 125 MHz.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 en_i  in  1  enable; low stops acceptance of writes.
REQ-008 wr_en_i  in  1  single-cycle sample write strobe.
REQ-009 ch_sel_i  in  2  bit0 updates ch1, bit1 updates ch2, both allowed.
REQ-010 data_i  in  DAC_DATA_WIDTH  signed sample value.
REQ-011 clr_i  in  1  clears the sticky overflow flag.
REQ-012 ramp_i  in  1  ramp mode request; used only when DAC_TX_RAMP_EN is defined.
REQ-013 step_i  in  DAC_DATA_WIDTH  unsigned ramp increment.
REQ-014 M_AXIS_tdata_o  out  AXIS_TDATA_WIDTH  ch1 in [15:0], ch2 in [31:16].
REQ-015 M_AXIS_tvalid_o  out  1  beat valid.
REQ-016 M_AXIS_tready_i  in  1  downstream ready.
REQ-017 callback_o  out  8  [7:6] state, [5] overflow, [4:0] FIFO fill level.

Function
REQ-018 SHALL implement the states ST_IDLE, ST_RUN and ST_DRAIN:
- ST_IDLE -> ST_RUN when en_i=1.
- ST_RUN -> ST_DRAIN when en_i=0.
- ST_DRAIN -> ST_IDLE when the FIFO is empty.
- ST_DRAIN -> ST_RUN when en_i=1.
REQ-019 SHALL ignore wr_en_i outside ST_RUN.
REQ-020 SHALL handle wr_en_i in ST_RUN as follows:
- update the selected channel holding registers;
- push one beat built from the updated holding registers;
- ch_sel_i=0 pushes the unchanged pair.
REQ-021 Each lane SHALL be the sample sign-extended to 16 bits.
REQ-022 A write at cycle N into an empty FIFO SHALL assert tvalid at N+1.
REQ-023 A beat SHALL transfer only when tvalid and tready are both high.
REQ-024 tdata SHALL be held stable while tvalid=1 and tready=0.
REQ-025 tvalid SHALL NOT deassert before its beat transfers.
REQ-026 tvalid SHALL be 0 when the FIFO is empty.
REQ-027 A push while full SHALL be accepted only if a pop occurs in the same cycle.
REQ-028 A push while full with no pop SHALL be dropped and SHALL set overflow.
REQ-029 Simultaneous push and pop at any non-full level SHALL leave the fill level unchanged.
REQ-030 Overflow SHALL stay set until clr_i.
REQ-031 When clr_i coincides with a new overflow, the overflow SHALL win.
REQ-032 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 The fill level SHALL range 0..FIFO_DEPTH.
REQ-034 In ST_DRAIN, beats already queued SHALL still be emitted in order.

Reset
REQ-035 While rst_n=0, the block SHALL be in the following reset state:
- state = ST_IDLE;
- FIFO empty;
- holding registers = 0;
- overflow = 0;
- ramp accumulator = 0;
- tvalid = 0;
- tdata = 0;
- callback_o = 0.
REQ-036 Reset asserted mid-beat SHALL discard all queued beats with no partial output.
REQ-037 Deassertion of rst_n SHALL pass through a two-flop synchronizer inside the block.

Configuration
REQ-038 With macro DAC_TX_RAMP_EN defined, the block SHALL behave as follows in ST_RUN with ramp_i=1:
- push a beat whenever the FIFO is not full;
- ch1 = accumulator, ch2 = current holding register;
- add step_i to the accumulator after each accepted push;
- wrap +8191 -> -8192 (two's complement);
- ignore wr_en_i.
REQ-039 Without DAC_TX_RAMP_EN, ramp_i and step_i SHALL be ignored and no ramp logic SHALL be synthesized.

Structure
REQ-040 Package pdh_pkg SHALL hold the state_t enum, the lane width (16) and the lane offsets.
REQ-041 The FIFO SHALL be a sub-module named axis_sync_fifo with push/pop/full/empty/level ports.

Verification
REQ-042 Write ch1=0x1FFF, ch2=0x2000 (ch_sel 2'b11), tready=1 -> one beat 0xE0001FFF at N+1.
REQ-043 Hold tready=0 and write 5 beats, depth 4 -> 4 beats queued, overflow=1; clr_i -> overflow=0; release tready -> 4 beats in order.
REQ-044 FIFO full plus write plus tready=1 in the same cycle -> write accepted, level stays 4, no overflow.
REQ-045 en_i dropped with 3 beats queued -> ST_DRAIN, 3 beats out, ST_IDLE, later writes ignored.
REQ-046 rst_n pulsed low while tvalid=1 and tready=0 -> tvalid=0 immediately, level 0.
REQ-047 DAC_TX_RAMP_EN, step_i=4096, start 0 -> ch1 sequence 0, 4096, -8192, -4096, 0.
